// File: rtl/aes_round_ctrl_pkg.sv
// Shared types for the AES round controller: FSM state encoding, round count
// and the 128-bit cipher state type.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_e;

  localparam int AES_NR = 10;

  typedef logic [127:0] aes_state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake bus between the round controller and the round transform.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic       tf_start;
  aes_state_t tf_s;
  aes_state_t tf_sr;
  aes_state_t tf_mc;
  logic       tf_done;

  modport ctrl  (output tf_start, output tf_s, input tf_sr, input tf_mc, input tf_done);
  modport xform (input tf_start, input tf_s, output tf_sr, output tf_mc, output tf_done);

endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: whitens the plaintext, hands each round to an external
// round transform, adds the round key to its result and reports the ciphertext.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR       = AES_NR,
  parameter int DONE_GAP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  aes_state_t pt_i,
  output logic       ready_o,
  output logic [3:0] rk_idx_o,
  input  aes_state_t rk_i,
  output logic       tf_start_o,
  output aes_state_t tf_s_o,
  input  aes_state_t tf_sr_i,
  input  aes_state_t tf_mc_i,
  input  logic       tf_done_i,
  output aes_state_t ct_o,
  output logic       valid_o
);

  localparam int GW = (DONE_GAP > 0) ? $clog2(DONE_GAP + 1) : 1;

  state_e          state_q, state_d;
  logic [3:0]      round_q, round_d;
  aes_state_t      st_q, st_d;
  aes_state_t      ct_q, ct_d;
  logic [GW-1:0]   gap_q, gap_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      st_q    <= '0;
      ct_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    st_d       = st_q;
    ct_d       = ct_q;
    gap_d      = gap_q;
    ready_o    = 1'b0;
    tf_start_o = 1'b0;
    valid_o    = 1'b0;
    rk_idx_o   = round_q;

    case (state_q)
      IDLE: begin
        ready_o  = 1'b1;
        rk_idx_o = 4'd0;
        if (start_i) begin
          st_d    = pt_i ^ rk_i;
          round_d = 4'd1;
          state_d = START;
        end
      end
      START: begin
        tf_start_o = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (tf_done_i) begin
          if (round_q < 4'(NR)) begin
            st_d    = tf_mc_i ^ rk_i;
            round_d = round_q + 4'd1;
            state_d = START;
          end else begin
            // Last round skips MixColumns; ct is latched here so it outlives st.
            st_d    = tf_sr_i ^ rk_i;
            ct_d    = tf_sr_i ^ rk_i;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        valid_o  = 1'b1;
        rk_idx_o = 4'd0;
        gap_d    = '0;
        state_d  = (DONE_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        rk_idx_o = 4'd0;
        if (gap_q == GW'(DONE_GAP - 1)) state_d = IDLE;
        else                            gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tf_s_o = st_q;
  assign ct_o   = ct_q;

endmodule
